datamem_circ: RTL and testbench

Parametrised successor to the 256x16 data memory, for the DSP datapath. Single-port synchronous RAM with a registered read port and two addressing modes:
- Direct: address taken from the addr port.
- Circular: base + offset, with a hardware offset register that steps up or down and wraps inside a programmable window.

Circular mode serves FIR delay lines and coefficient tables without ALU address arithmetic.

---
 rtl/datamem_circ.sv | 93 +++++++++
 tb/tb_datamem_circ.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_circ.sv
// Single-port synchronous data memory with a registered read port and a
// direct / circular addressing mode for DSP delay lines and coefficient tables.
module datamem_circ #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      in,
    input  logic                  circ,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    input  logic                  step,
    input  logic                  dir,
    output logic [WIDTH-1:0]      out,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  wrap
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  wrap_q, wrap_d;
    logic [ADDR_WIDTH-1:0] ea;

    // Address sum truncates to ADDR_WIDTH, so a window may run past the top of memory.
    assign ptr = base_q + offset_q;
    assign ea  = circ ? ptr : addr;

    always_comb begin
        base_d   = base_q;
        len_d    = len_q;
        offset_d = offset_q;
        wrap_d   = 1'b0;
        out_d    = mem[ea];
        if (cfg_we) begin
            base_d   = cfg_base;
            len_d    = cfg_len;
            offset_d = '0;
        end else if (step && circ) begin
            if (!dir) begin
                if (offset_q == len_q) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + 1'b1;
                end
            end else begin
                if (offset_q == '0) begin
                    offset_d = len_q;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            len_q    <= '1;
            offset_q <= '0;
            out_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            base_q   <= base_d;
            len_q    <= len_d;
            offset_q <= offset_d;
            out_q    <= out_d;
            wrap_q   <= wrap_d;
        end
    end

    // Contents survive reset; reset only suppresses a write in its own cycle.
    always_ff @(posedge clk) begin
        if (!reset && en) begin
            mem[ea] <= in;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_datamem_circ.sv
// Bench for datamem_circ: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the memory and window.
module tb_datamem_circ;

    localparam int W     = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [AW-1:0] addr;
    logic [W-1:0]  in;
    logic          circ;
    logic          cfg_we;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_len;
    logic          step;
    logic          dir;
    logic [W-1:0]  out;
    logic [AW-1:0] ptr;
    logic          wrap;

    datamem_circ #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .en(en), .addr(addr), .in(in),
        .circ(circ), .cfg_we(cfg_we), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .step(step), .dir(dir), .out(out), .ptr(ptr), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] mem_m [DEPTH];
    int           base_m, len_m, off_m;
    logic [W-1:0] out_m;
    logic         wrap_m;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_ptr();
        return (base_m + off_m) % DEPTH;
    endfunction

    // One clock edge of the model, from the documented rules.
    task automatic model_edge();
        int ea;
        if (reset) begin
            base_m = 0; len_m = DEPTH - 1; off_m = 0;
            out_m  = '0; wrap_m = 1'b0;
        end else begin
            ea    = circ ? model_ptr() : int'(addr);
            out_m = mem_m[ea];
            if (en) mem_m[ea] = in;
            if (cfg_we) begin
                base_m = int'(cfg_base); len_m = int'(cfg_len); off_m = 0;
                wrap_m = 1'b0;
            end else if (step && circ) begin
                if (!dir) begin
                    wrap_m = (off_m == len_m);
                    off_m  = (off_m + 1) % (len_m + 1);
                end else begin
                    wrap_m = (off_m == 0);
                    off_m  = (off_m + len_m) % (len_m + 1);
                end
            end else begin
                wrap_m = 1'b0;
            end
        end
    endtask

    task automatic idle();
        reset = 1'b0; en = 1'b0; addr = '0; in = '0; circ = 1'b0;
        cfg_we = 1'b0; cfg_base = '0; cfg_len = '0; step = 1'b0; dir = 1'b0;
    endtask

    // Apply the current inputs for one clock and compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("out", 32'(out), 32'(out_m));
        check("ptr", 32'(ptr), 32'(model_ptr()));
        check("wrap", 32'(wrap), 32'(wrap_m));
    endtask

    task automatic write_direct(input logic [AW-1:0] a, input logic [W-1:0] d);
        idle(); en = 1'b1; addr = a; in = d;
        tick();
    endtask

    task automatic read_direct(input logic [AW-1:0] a);
        idle(); addr = a;
        tick();
    endtask

    task automatic load_window(input logic [AW-1:0] b, input logic [AW-1:0] l);
        idle(); cfg_we = 1'b1; cfg_base = b; cfg_len = l;
        tick();
    endtask

    logic [AW-1:0] exp_ptr [6];

    initial begin
        base_m = 0; len_m = DEPTH - 1; off_m = 0; out_m = '0; wrap_m = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        // Reset state
        idle(); reset = 1'b1;
        tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_ptr", 32'(ptr), 32'h0);

        // Preload whole memory: 1..5 at 0..4, random elsewhere
        for (int i = 0; i < DEPTH; i++)
            write_direct(8'(i), (i < 5) ? 16'(i + 1) : 16'($urandom));

        // Test 1: direct reads with one-cycle latency
        for (int i = 0; i < 5; i++) begin
            read_direct(8'(i));
            check("t1_read", 32'(out), 32'(i + 1));
        end
        idle(); reset = 1'b1; en = 1'b1; addr = 8'h00; in = 16'hdead;
        tick();
        check("t1_rst_out", 32'(out), 32'h0);
        read_direct(8'h00);
        check("t1_mem0", 32'(out), 32'h1);

        // Test 2: read-before-write then read back
        write_direct(8'h10, 16'habcd);
        read_direct(8'h10);
        check("t2_rdback", 32'(out), 32'habcd);
        write_direct(8'h10, 16'h1234);
        check("t2_rbw", 32'(out), 32'habcd);

        // Test 3: circular increment over F0..F3
        load_window(8'hF0, 8'd3);
        exp_ptr = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF0, 8'hF1};
        for (int k = 0; k < 5; k++) begin
            check("t3_ptr", 32'(ptr), 32'(exp_ptr[k]));
            idle(); circ = 1'b1; step = 1'b1; en = 1'b1; in = 16'(100 + k);
            tick();
            check("t3_wrap", 32'(wrap), (k == 3) ? 32'h1 : 32'h0);
        end
        check("t3_ptr_end", 32'(ptr), 32'(exp_ptr[5]));
        for (int k = 0; k < 4; k++) begin
            read_direct(8'(8'hF0 + k));
            check("t3_mem", 32'(out), (k == 0) ? 32'd104 : 32'(100 + k));
        end

        // Test 4: window running past the top of memory
        load_window(8'hFE, 8'd3);
        exp_ptr = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            check("t4_ptr", 32'(ptr), 32'(exp_ptr[k]));
            idle(); circ = 1'b1; step = 1'b1;
            tick();
            check("t4_wrap", 32'(wrap), (k == 3) ? 32'h1 : 32'h0);
        end
        check("t4_ptr_end", 32'(ptr), 32'hFE);

        // Test 5: decrement, len=0, and step outside circular mode
        load_window(8'h20, 8'd2);
        exp_ptr = '{8'h22, 8'h21, 8'h20, 8'h22, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
            idle(); circ = 1'b1; step = 1'b1; dir = 1'b1;
            tick();
            check("t5_dec_ptr", 32'(ptr), 32'(exp_ptr[k]));
            check("t5_dec_wrap", 32'(wrap), (k == 0) ? 32'h1 : 32'h0);
        end
        load_window(8'h20, 8'd0);
        for (int k = 0; k < 3; k++) begin
            idle(); circ = 1'b1; step = 1'b1; dir = k[0];
            tick();
            check("t5_len0_ptr", 32'(ptr), 32'h20);
            check("t5_len0_wrap", 32'(wrap), 32'h1);
        end
        idle(); step = 1'b1;
        tick();
        check("t5_nocirc_ptr", 32'(ptr), 32'h20);
        check("t5_nocirc_wrap", 32'(wrap), 32'h0);

        // Test 6: cfg_we beats step; reset mid-stream blocks the write
        load_window(8'h40, 8'd7);
        idle(); circ = 1'b1; step = 1'b1;
        tick();
        idle(); circ = 1'b1; step = 1'b1; cfg_we = 1'b1; cfg_base = 8'h50; cfg_len = 8'd3;
        tick();
        check("t6_prio_ptr", 32'(ptr), 32'h50);
        check("t6_prio_wrap", 32'(wrap), 32'h0);
        idle(); circ = 1'b1; step = 1'b1; en = 1'b1; in = 16'h7777;
        tick();
        idle(); reset = 1'b1; circ = 1'b1; step = 1'b1; en = 1'b1; in = 16'h5555;
        tick();
        check("t6_rst_ptr", 32'(ptr), 32'h0);
        read_direct(8'h51);
        check("t6_nowrite", 32'(out) == 32'h5555 ? 32'h1 : 32'h0, 32'h0);
        idle(); circ = 1'b1; step = 1'b1;
        for (int k = 0; k < 255; k++) tick();
        check("t6_full_wrap", 32'(wrap), 32'h0);
        tick();
        check("t6_full_wrap_end", 32'(wrap), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset    = ($urandom_range(0, 99) == 0);
            en       = $urandom_range(0, 1) == 1;
            addr     = 8'($urandom);
            in       = 16'($urandom);
            circ     = $urandom_range(0, 3) != 0;
            cfg_we   = ($urandom_range(0, 15) == 0);
            cfg_base = 8'($urandom);
            cfg_len  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            step     = $urandom_range(0, 2) != 0;
            dir      = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
